// File: rtl/hazard_controller.sv
// Hazard and sequencing controller: forwarding, load-use and branch flush, plus mul/div hold with watchdog.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_controller #(
  parameter int MD_TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        ResultSrcE0,
  input  logic        PCSrcE,
  input  logic        MulDivStartE,
  input  logic        MulDivDoneE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic        MdBusy,
  output logic        MdTimeout,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
);
  // state   | meaning
  // IDLE    | no multi-cycle op held in E
  // MD_WAIT | mul/div op held in E, waiting for done or watchdog

  localparam int CW = $clog2(MD_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MD_TIMEOUT - 1);

  typedef enum logic {IDLE, MD_WAIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          timeout_hit;
  logic          lw_stall;
  logic          md_stall;

  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && RdM != 5'd0 && Rs1E == RdM)      ForwardAE = 2'b10;
    else if (RegWriteW && RdW != 5'd0 && Rs1E == RdW) ForwardAE = 2'b01;
    ForwardBE = 2'b00;
    if (RegWriteM && RdM != 5'd0 && Rs2E == RdM)      ForwardBE = 2'b10;
    else if (RegWriteW && RdW != 5'd0 && Rs2E == RdW) ForwardBE = 2'b01;
  end

  assign lw_stall    = ResultSrcE0 && RdE != 5'd0 && (Rs1D == RdE || Rs2D == RdE);
  assign timeout_hit = (state == MD_WAIT) && (cnt == CNT_LAST);
  assign md_stall    = (state == IDLE && MulDivStartE) ||
                       (state == MD_WAIT && !MulDivDoneE && !timeout_hit);

  always_comb begin
    StallF = lw_stall;
    StallD = lw_stall;
    StallE = 1'b0;
    FlushD = PCSrcE;
    FlushE = lw_stall | PCSrcE;
    FlushM = 1'b0;
    // A held mul/div op owns the pipe: branch and load-use wait until release
    if (md_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushM = 1'b1;
    end
  end

  assign MdBusy    = (state == MD_WAIT);
  assign MdTimeout = timeout_hit && !MulDivDoneE;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (MulDivStartE) state <= MD_WAIT;
        end
        MD_WAIT: begin
          if (MulDivDoneE || timeout_hit) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallD) stall_cnt <= stall_cnt + 32'd1;
      if (FlushD) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign StallCount = stall_cnt;
  assign FlushCount = flush_cnt;
`else
  assign StallCount = 32'd0;
  assign FlushCount = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with MD_TIMEOUT=8; expected values are hand-computed.
module tb_hazard_controller;
  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MulDivStartE, MulDivDoneE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy, MdTimeout;
  logic [31:0] StallCount, FlushCount;

  int tests = 0;
  int fails = 0;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  hazard_controller #(.MD_TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .MulDivStartE(MulDivStartE), .MulDivDoneE(MulDivDoneE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .MdBusy(MdBusy), .MdTimeout(MdTimeout),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // stall = {StallF,StallD,StallE}, flush = {FlushD,FlushE,FlushM}
  task automatic chk_ctl(input string tag, input logic [2:0] stall, input logic [2:0] flush);
    chk({tag, "_stall"}, {29'd0, StallF, StallD, StallE}, {29'd0, stall});
    chk({tag, "_flush"}, {29'd0, FlushD, FlushE, FlushM}, {29'd0, flush});
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0;
    MulDivStartE = 0; MulDivDoneE = 0;
    step();
    step();
    chk("rst_busy", {31'd0, MdBusy}, 32'd0);
    chk("rst_tmo", {31'd0, MdTimeout}, 32'd0);
    chk("rst_scnt", StallCount, 32'd0);
    chk("rst_fcnt", FlushCount, 32'd0);
    chk_ctl("rst", 3'b000, 3'b000);
    reset = 1'b0;

    // forwarding
    RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; Rs2E = 0;
    #1;
    chk("fwdA_m", {30'd0, ForwardAE}, 32'd2);
    chk("fwdB_x0", {30'd0, ForwardBE}, 32'd0);
    RdM = 0;
    #1;
    chk("fwdA_w", {30'd0, ForwardAE}, 32'd1);
    RdM = 9; Rs2E = 9;
    #1;
    chk("fwdB_m", {30'd0, ForwardBE}, 32'd2);
    RegWriteM = 0;
    #1;
    chk("fwdB_nowe", {30'd0, ForwardBE}, 32'd0);
    RegWriteM = 0; RegWriteW = 0; RdM = 0; RdW = 0; Rs1E = 0; Rs2E = 0;

    // load-use
    step();
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
    #1;
    chk_ctl("lw_rs2", 3'b110, 3'b010);
    step();
    RdE = 0;
    #1;
    chk_ctl("lw_rd0", 3'b000, 3'b000);
    chk("lw_scnt", StallCount, PERF ? 32'd1 : 32'd0);
    ResultSrcE0 = 0; Rs2D = 0;

    // taken branch
    PCSrcE = 1;
    #1;
    chk_ctl("br", 3'b000, 3'b110);
    step();
    PCSrcE = 0;
    #1;
    chk("br_fcnt", FlushCount, PERF ? 32'd1 : 32'd0);
    chk("br_scnt", StallCount, PERF ? 32'd1 : 32'd0);

    // load-use and branch together, cleared before the edge
    ResultSrcE0 = 1; RdE = 7; Rs1D = 7; PCSrcE = 1;
    #1;
    chk_ctl("lwbr", 3'b110, 3'b110);
    ResultSrcE0 = 0; RdE = 0; Rs1D = 0; PCSrcE = 0;

    // done in IDLE is ignored
    step();
    MulDivDoneE = 1;
    #1;
    chk_ctl("done_idle", 3'b000, 3'b000);
    step();
    MulDivDoneE = 0;
    #1;
    chk("done_idle_busy", {31'd0, MdBusy}, 32'd0);

    // mul/div handshake, done 4 cycles after start
    MulDivStartE = 1;
    #1;
    chk_ctl("md_c0", 3'b111, 3'b001);
    chk("md_c0_busy", {31'd0, MdBusy}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      #1;
      chk_ctl("md_hold", 3'b111, 3'b001);
      chk("md_hold_busy", {31'd0, MdBusy}, 32'd1);
      if (k == 2) begin
        PCSrcE = 1;
        #1;
        chk_ctl("md_hold_br", 3'b111, 3'b001);
        PCSrcE = 0;
      end
    end
    step();
    MulDivDoneE = 1;
    #1;
    chk_ctl("md_done", 3'b000, 3'b000);
    chk("md_done_busy", {31'd0, MdBusy}, 32'd1);
    chk("md_done_tmo", {31'd0, MdTimeout}, 32'd0);
    step();
    MulDivDoneE = 0; MulDivStartE = 0;
    #1;
    chk("md_idle_busy", {31'd0, MdBusy}, 32'd0);
    chk_ctl("md_idle", 3'b000, 3'b000);
    chk("md_scnt", StallCount, PERF ? 32'd5 : 32'd0);

    // watchdog timeout, done never asserted
    step();
    MulDivStartE = 1;
    #1;
    chk_ctl("to_c0", 3'b111, 3'b001);
    for (int k = 1; k <= 8; k++) begin
      step();
      #1;
      chk("to_busy", {31'd0, MdBusy}, 32'd1);
      if (k < 8) begin
        chk("to_tmo_lo", {31'd0, MdTimeout}, 32'd0);
        chk_ctl("to_hold", 3'b111, 3'b001);
      end else begin
        chk("to_tmo_hi", {31'd0, MdTimeout}, 32'd1);
        chk_ctl("to_rel", 3'b000, 3'b000);
      end
    end
    step();
    MulDivStartE = 0;
    #1;
    chk("to_after_busy", {31'd0, MdBusy}, 32'd0);
    chk("to_after_tmo", {31'd0, MdTimeout}, 32'd0);
    chk("to_scnt", StallCount, PERF ? 32'd13 : 32'd0);

    // reset during MD_WAIT at its third cycle
    step();
    MulDivStartE = 1;
    for (int k = 1; k <= 3; k++) step();
    #1;
    chk("rw_busy_pre", {31'd0, MdBusy}, 32'd1);
    reset = 1;
    step();
    reset = 0; MulDivStartE = 0;
    #1;
    chk("rw_busy", {31'd0, MdBusy}, 32'd0);
    chk("rw_tmo", {31'd0, MdTimeout}, 32'd0);
    chk("rw_scnt", StallCount, 32'd0);
    chk("rw_fcnt", FlushCount, 32'd0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("rw_quiet", {30'd0, MdBusy, MdTimeout}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
